// File: rtl/alu_bist.sv
// Self-test initiator for the 64-bit ALU: drives one vector per cycle and checks result/zero.
// Directed zero-operand phase for the first seven vectors, then two Galois LFSRs supply operands.
module alu_bist #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [63:0] SEED_A      = 64'h0123_4567_89AB_CDEF,
  parameter logic [63:0] SEED_B      = 64'hFEDC_BA98_7654_3210
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [63:0] a_out,
  output logic [63:0] b_out,
  output logic [3:0]  alu_ctrl_out,
  input  logic [63:0] result_in,
  input  logic        zero_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] fail_index,
  output logic [3:0]  fail_op
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] LFSR_VEC    = 16'd7;
  localparam logic [63:0] LFSR_TAPS   = 64'hD800_0000_0000_0000;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] k;
  logic [2:0]  op_idx;
  logic [63:0] lfsr_a;
  logic [63:0] lfsr_b;
  logic        first_fail;

  logic        in_run;
  logic        last_vec;
  logic        launch;
  logic        lfsr_phase;
  logic [3:0]  op_code;
  logic [63:0] exp_result;
  logic        exp_zero;
  logic        mismatch;

  function automatic logic [63:0] lfsr_step(input logic [63:0] x);
    // Right-shifting Galois form of x^64+x^63+x^61+x^60+1
    lfsr_step = (x >> 1) ^ ({64{x[0]}} & LFSR_TAPS);
  endfunction

  assign in_run     = (state == RUN);
  assign last_vec   = (k == LAST_VEC);
  assign launch     = ((state == IDLE) || (state == DONE)) && start;
  assign lfsr_phase = (k >= LFSR_VEC);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_vec) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_code = 4'b0000;
    unique case (op_idx)
      3'd0:    op_code = 4'b0000;
      3'd1:    op_code = 4'b0001;
      3'd2:    op_code = 4'b0010;
      3'd3:    op_code = 4'b0110;
      3'd4:    op_code = 4'b0111;
      3'd5:    op_code = 4'b1100;
      3'd6:    op_code = 4'b0011;
      default: op_code = 4'b0000;
    endcase
  end

  always_comb begin
    a_out        = 64'd0;
    b_out        = 64'd0;
    alu_ctrl_out = 4'b0000;
    if (in_run) begin
      alu_ctrl_out = op_code;
      if (lfsr_phase) begin
        a_out = lfsr_a;
        b_out = lfsr_b;
      end
    end
  end

  // Golden model works on the driven operands so both phases share one path.
  always_comb begin
    exp_result = 64'd0;
    unique case (op_idx)
      3'd0:    exp_result = a_out & b_out;
      3'd1:    exp_result = a_out | b_out;
      3'd2:    exp_result = a_out + b_out;
      3'd3:    exp_result = a_out - b_out;
      3'd4:    exp_result = b_out;
      3'd5:    exp_result = ~(a_out | b_out);
      default: exp_result = 64'd0;
    endcase
  end

  assign exp_zero = (exp_result == 64'd0);
  assign mismatch = (result_in != exp_result) || (zero_in != exp_zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= 16'd0;
      op_idx     <= 3'd0;
      lfsr_a     <= SEED_A;
      lfsr_b     <= SEED_B;
      first_fail <= 1'b0;
      err_count  <= 16'd0;
      fail_index <= 16'd0;
      fail_op    <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (launch) begin
        k          <= 16'd0;
        op_idx     <= 3'd0;
        lfsr_a     <= SEED_A;
        lfsr_b     <= SEED_B;
        first_fail <= 1'b0;
        err_count  <= 16'd0;
        fail_index <= 16'd0;
        fail_op    <= 4'b0000;
      end else if (in_run) begin
        k      <= k + 16'd1;
        op_idx <= (op_idx == 3'd6) ? 3'd0 : op_idx + 3'd1;
        // Vector 7 consumes the seeds; each later vector advances once.
        if (lfsr_phase) begin
          lfsr_a <= lfsr_step(lfsr_a);
          lfsr_b <= lfsr_step(lfsr_b);
        end
        if (mismatch) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (!first_fail) begin
            first_fail <= 1'b1;
            fail_index <= k;
            fail_op    <= op_code;
          end
        end
      end
    end
  end

  assign busy = in_run;
  assign done = (state == DONE);
  assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU with selectable faults, vector scoreboard and end-of-run checks.
module tb_alu_bist;

  localparam int          NV = 16;
  localparam logic [63:0] SA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SB = 64'hFEDC_BA98_7654_3210;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctrl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] a_out, b_out, result_in;
  logic [3:0]  alu_ctrl_out, fail_op;
  logic        zero_in, busy, done, pass;
  logic [15:0] err_count, fail_index;

  int   fault_mode = 0;
  int   total = 0;
  int   bad = 0;
  vec_t q[$];
  logic [15:0] exp_err, exp_fidx;
  logic [3:0]  exp_fop;

  always #5 clk = ~clk;

  alu_bist #(.NUM_VECTORS(NV), .SEED_A(SA), .SEED_B(SB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_out(a_out), .b_out(b_out), .alu_ctrl_out(alu_ctrl_out),
    .result_in(result_in), .zero_in(zero_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_index(fail_index), .fail_op(fail_op)
  );

  // ALU reference with injectable faults: 1 = ADD off by one, 2 = zero stuck low,
  // 3 = unused code returns all ones. Returns {zero, result}.
  function automatic logic [64:0] alu(input logic [3:0] c, input logic [63:0] a,
                                      input logic [63:0] b, input int f);
    logic [63:0] r;
    logic        z;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = (f == 1) ? a + b + 64'd1 : a + b;
      4'b0110: r = a - b;
      4'b0111: r = b;
      4'b1100: r = ~(a | b);
      4'b0011: r = (f == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
      default: r = 64'd0;
    endcase
    z = (f == 2) ? 1'b0 : (r == 64'd0);
    return {z, r};
  endfunction

  always_comb begin
    {zero_in, result_in} = alu(alu_ctrl_out, a_out, b_out, fault_mode);
  end

  function automatic logic [3:0] code_of(input int i);
    case (i)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0111;
      5: return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  function automatic logic [63:0] step(input logic [63:0] x);
    logic fb;
    fb = x[0];
    x  = {1'b0, x[63:1]};
    if (fb) begin
      x[63] = ~x[63];
      x[62] = ~x[62];
      x[60] = ~x[60];
      x[59] = ~x[59];
    end
    return x;
  endfunction

  // Push the whole expected vector stream and predict the error summary for a fault.
  task automatic plan_run(input int f);
    logic [63:0] la, lb;
    logic [64:0] good, got;
    vec_t        v;
    bit          found;
    la = SA; lb = SB; found = 0;
    exp_err = 0; exp_fidx = 0; exp_fop = 0;
    for (int i = 0; i < NV; i++) begin
      v.ctrl = code_of(i % 7);
      v.a    = (i < 7) ? 64'd0 : la;
      v.b    = (i < 7) ? 64'd0 : lb;
      q.push_back(v);
      good = alu(v.ctrl, v.a, v.b, 0);
      got  = alu(v.ctrl, v.a, v.b, f);
      if (got !== good) begin
        if (exp_err != 16'hFFFF) exp_err++;
        if (!found) begin
          found = 1; exp_fidx = 16'(i); exp_fop = v.ctrl;
        end
      end
      if (i >= 7) begin
        la = step(la); lb = step(lb);
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_run(input int f, input bit glitch, input bit abort);
    vec_t v;
    fault_mode = f;
    plan_run(f);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < NV; i++) begin
      v = q.pop_front();
      check($sformatf("a_out[%0d]", i), a_out, v.a);
      check($sformatf("b_out[%0d]", i), b_out, v.b);
      check($sformatf("ctrl[%0d]", i), 64'(alu_ctrl_out), 64'(v.ctrl));
      check($sformatf("busy[%0d]", i), 64'(busy), 64'd1);
      if (abort && i == 5) begin
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_err", 64'(err_count), 64'd0);
        check("abort_a", a_out, 64'd0);
        check("abort_b", b_out, 64'd0);
        q.delete();
        return;
      end
      start = glitch && (i == 5);
      @(negedge clk);
    end
    start = 1'b0;
    check("end_busy", 64'(busy), 64'd0);
    check("end_done", 64'(done), 64'd1);
    check("end_pass", 64'(pass), 64'(exp_err == 16'd0));
    check("end_err", 64'(err_count), 64'(exp_err));
    check("end_fidx", 64'(fail_index), 64'(exp_fidx));
    check("end_fop", 64'(fail_op), 64'(exp_fop));
    check("end_a_idle", a_out, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_a", a_out, 64'd0);
    check("rst_b", b_out, 64'd0);
    check("rst_ctrl", 64'(alu_ctrl_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_fidx", 64'(fail_index), 64'd0);
    check("rst_fop", 64'(fail_op), 64'd0);

    // Clean ALU with a start pulse mid-run, then a restart from DONE.
    do_run(0, 1'b1, 1'b0);
    check("clean_pass", 64'(pass), 64'd1);
    do_run(0, 1'b0, 1'b0);
    check("restart_pass", 64'(pass), 64'd1);

    // ADD off by one: first failure is vector 2.
    do_run(1, 1'b0, 1'b0);
    check("add_fidx", 64'(fail_index), 64'd2);
    check("add_fop", 64'(fail_op), 64'b0010);
    check("add_pass", 64'(pass), 64'd0);

    // Zero flag stuck low: vector 0 fails, NOR vector does not.
    do_run(2, 1'b0, 1'b0);
    check("zero_fidx", 64'(fail_index), 64'd0);
    check("zero_fop", 64'(fail_op), 64'b0000);

    // Unused code returning all ones: vectors 6 and 13 fail.
    do_run(3, 1'b0, 1'b0);
    check("unused_err", 64'(err_count), 64'd2);
    check("unused_fidx", 64'(fail_index), 64'd6);

    // Abort during vector 5, then a clean full run.
    do_run(0, 1'b0, 1'b1);
    check("post_abort_idle_done", 64'(done), 64'd0);
    do_run(0, 1'b0, 1'b0);
    check("post_abort_pass", 64'(pass), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
